// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use, taken-branch and mul/div hazards
// resolved into PC/IF-ID write enables and IF-ID/ID-EX flushes.
module hazard_control #(
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int MULDIV_CYCLES       = 4,
    parameter int CNT_W               = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       id_RR1,
    input  logic [3:0]       id_RR2,
    input  logic             id_useRR1,
    input  logic             id_useRR2,
    input  logic             id_isMulDiv,
    input  logic             idex_memRead,
    input  logic [3:0]       idex_wAddr,
    input  logic             ex_branchTaken,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             busy,
    output logic [CNT_W-1:0] stallCount
);

    localparam int MAX_CYC = (BRANCH_FLUSH_CYCLES > MULDIV_CYCLES) ? BRANCH_FLUSH_CYCLES : MULDIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {RUN, BR_FLUSH, MD_STALL} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          md_grant, next_grant;
    logic          load_use;
    logic          pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c;

    assign load_use = idex_memRead &
                      ((id_useRR1 & (id_RR1 == idex_wAddr)) |
                       (id_useRR2 & (id_RR2 == idex_wAddr)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cnt        <= '0;
            md_grant   <= 1'b0;
            stallCount <= '0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            md_grant <= next_grant;
            if (!pcWrite && (stallCount != {CNT_W{1'b1}}))
                stallCount <= stallCount + 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_grant   = md_grant;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;

        unique case (state)
            RUN: begin
                if (ex_branchTaken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    next_grant   = 1'b0;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        next_state = BR_FLUSH;
                        next_cnt   = CW'(BRANCH_FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (id_isMulDiv && !md_grant) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                    next_state   = MD_STALL;
                    next_cnt     = CW'(MULDIV_CYCLES - 1);
                end else begin
                    // ID advances this cycle, so any granted mul/div has issued
                    next_grant = 1'b0;
                end
            end
            BR_FLUSH: begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                if (cnt == CW'(1)) begin
                    next_state = RUN;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            MD_STALL: begin
                if (ex_branchTaken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    next_grant   = 1'b0;
                    if (BRANCH_FLUSH_CYCLES > 1) begin
                        next_state = BR_FLUSH;
                        next_cnt   = CW'(BRANCH_FLUSH_CYCLES - 1);
                    end else begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end else begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                    if (cnt == CW'(1)) begin
                        next_state = RUN;
                        next_cnt   = '0;
                        next_grant = 1'b1;
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = '0;
                next_grant = 1'b0;
            end
        endcase
    end

    // Holding reset overrides every output so downstream buffers see a clean RUN
    assign pcWrite   = !reset | pc_write_c;
    assign ifidWrite = !reset | ifid_write_c;
    assign ifidFlush = reset & ifid_flush_c;
    assign idexFlush = reset & idex_flush_c;
    assign busy      = reset & (state != RUN);

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
Pipeline hazard controller that drives the ID/EX buffer flush input and the PC / IF/ID write enables. It detects three hazards: load-use dependencies against the instruction in EX, taken branches resolved in EX, and multi-cycle mul/div instructions held in ID. From these it generates stalls and bubbles with fixed priority. It sits beside the ID stage and consumes the ID/EX buffer's memRead and wAddr outputs.

Parameters:
BRANCH_FLUSH_CYCLES, 1, cycles flushes stay asserted per taken branch (>=1)
MULDIV_CYCLES, 4, bubble cycles inserted before a mul/div issues from ID (>=2)
CNT_W, 8, width of saturating stall counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low
id_RR1  in  4  source reg 1 of instruction in ID
id_RR2  in  4  source reg 2 of instruction in ID
id_useRR1  in  1  ID instruction reads id_RR1
id_useRR2  in  1  ID instruction reads id_RR2
id_isMulDiv  in  1  ID instruction is multi-cycle mul/div
idex_memRead  in  1  instruction in EX is a load (ID/EX buffer output)
idex_wAddr  in  4  dest reg of instruction in EX (ID/EX buffer output)
ex_branchTaken  in  1  branch in EX resolved taken
pcWrite  out  1  PC update enable
ifidWrite  out  1  IF/ID buffer load enable
ifidFlush  out  1  zero IF/ID buffer
idexFlush  out  1  zero ID/EX buffer (drives its flush input)
busy  out  1  state != RUN
stallCount  out  CNT_W  saturating count of cycles with pcWrite=0

Behaviour:
- Single clock. Reset is asynchronous, active-low, on "reset"; clock port is "clock".
- Registered state: state {RUN, BR_FLUSH, MD_STALL}, cnt (width for max(BRANCH_FLUSH_CYCLES, MULDIV_CYCLES)), mdGrant, stallCount.
- pcWrite/ifidWrite/ifidFlush/idexFlush/busy are combinational from state + inputs. They are sampled by downstream buffers on the same edge.
- Reset (reset=0): state=RUN, cnt=0, mdGrant=0, stallCount=0.
  - Outputs forced to pcWrite=1, ifidWrite=1, ifidFlush=0, idexFlush=0, busy=0, regardless of inputs.
  - Reset mid-operation aborts any stall/flush immediately.
- loadUse = idex_memRead & ((id_useRR1 & id_RR1==idex_wAddr) | (id_useRR2 & id_RR2==idex_wAddr)). R0 is not excluded.
- Priority, highest first: branch > loadUse > mul/div.
- RUN, branch:
  - Outputs: ifidFlush=1, idexFlush=1, pcWrite=1, ifidWrite=1.
  - If BRANCH_FLUSH_CYCLES>1: next=BR_FLUSH, cnt=BRANCH_FLUSH_CYCLES-1.
  - mdGrant cleared.
- RUN, loadUse (no branch):
  - Outputs: pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0.
  - Exactly one bubble; stays RUN.
- RUN, id_isMulDiv & !mdGrant (no branch, no loadUse):
  - Outputs: pcWrite=0, ifidWrite=0, idexFlush=1.
  - next=MD_STALL, cnt=MULDIV_CYCLES-1.
- RUN, otherwise: all enables 1, flushes 0.
  - If ifidWrite=1 that cycle, mdGrant cleared.
- BR_FLUSH:
  - Outputs: ifidFlush=1, idexFlush=1, pcWrite=1, ifidWrite=1. ex_branchTaken ignored.
  - cnt==1 -> RUN; else cnt--.
- MD_STALL:
  - Outputs: pcWrite=0, ifidWrite=0, idexFlush=1.
  - cnt==1 -> RUN with mdGrant=1; else cnt--.
  - ex_branchTaken preempts: branch outputs as in RUN; next=BR_FLUSH or RUN per BRANCH_FLUSH_CYCLES; mdGrant=0; mul/div is discarded.
- Mul/div total bubbles = MULDIV_CYCLES. The instruction issues in the RUN cycle where mdGrant=1, unless loadUse or branch intervenes there. mdGrant persists until ifidWrite=1 in RUN.
- stallCount: increments on each edge where pcWrite=0 and reset=1. Saturates at 2^CNT_W-1 with no wrap.
- Outputs never X when inputs are known. No internal combinational loops.

Test Plan:
- Load-use: idex_memRead=1, idex_wAddr=3, id_RR2=3, id_useRR2=1 for one cycle -> pcWrite=0, ifidWrite=0, idexFlush=1 that cycle only; stallCount 0->1.
- Branch, BRANCH_FLUSH_CYCLES=2: ex_branchTaken=1 one cycle -> ifidFlush=idexFlush=1 for 2 consecutive cycles, pcWrite=1 throughout, busy=1 in the 2nd cycle only.
- Mul/div, MULDIV_CYCLES=4: id_isMulDiv held 1 -> pcWrite=0 and idexFlush=1 for exactly 4 cycles, then pcWrite=1, ifidWrite=1, idexFlush=0; stallCount=4; no re-stall on the same instruction.
- Branch preempts mul/div: ex_branchTaken=1 in the 2nd MD_STALL cycle -> flushes asserted, pcWrite=1, state RUN next, mdGrant=0.
- Reset mid-MD_STALL: reset=0 asynchronously -> outputs immediately pcWrite=1, idexFlush=0, busy=0, stallCount=0; after release, behaves as fresh RUN.
- Saturation, CNT_W=4: 20 consecutive load-use cycles -> stallCount stops at 15.
